// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
//   ADD_*_DFLT : default operand width, segment width and tag width
//   stages_f   : number of pipeline stages for a given width / segment width
//   add_flags_t: carry / signed-overflow pair carried with each stage payload
package adder_pkg;

  localparam int ADD_WIDTH_DFLT = 32;
  localparam int ADD_SEG_W_DFLT = 8;
  localparam int ADD_TAG_W_DFLT = 4;

  // Illegal combinations are reported at elaboration by the top module.
  // Returning 1 for them keeps array sizes sane so that the report is
  // the only error the user sees.
  function automatic int stages_f(input int width, input int seg_w);
    if (seg_w < 1) return 1;
    if (width / seg_w < 1) return 1;
    return width / seg_w;
  endfunction

  // cout: carry out of the segment handled so far (final carry at the output)
  // ovf : signed overflow, only meaningful after the last segment
  typedef struct packed {
    logic cout;
    logic ovf;
  } add_flags_t;

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_W-bit adder slice used once per pipeline stage.
//   a, b    : segment operands
//   cin     : carry into the segment LSB
//   s       : segment sum
//   cout    : carry out of the segment MSB
//   msb_cin : carry into the segment MSB (signed overflow = msb_cin ^ cout)
module adder_seg
  import adder_pkg::*;
#(
  parameter int SEG_W = ADD_SEG_W_DFLT
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [SEG_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
  assign s    = full[SEG_W-1:0];
  assign cout = full[SEG_W];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out of it.
  assign msb_cin = a[SEG_W-1] ^ b[SEG_W-1] ^ full[SEG_W-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder: (in_a + in_b + in_cin) mod 2^WIDTH.
// The carry chain is cut into STAGES = WIDTH/SEG_W segments with one
// register stage per segment; a result appears STAGES edges after accept.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : input handshake (in_ready = ~stall)
//   in_a, in_b, in_cin   : operands and carry-in
//   in_tag               : sideband tag returned with the result
//   out_valid / out_ready: output handshake
//   out_sum              : WIDTH-bit sum
//   out_cout             : unsigned carry out of the MSB
//   out_ovf              : signed overflow
//   out_tag              : tag of the transaction being presented
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DFLT,
  parameter int SEG_W = ADD_SEG_W_DFLT,
  parameter int TAG_W = ADD_TAG_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = stages_f(WIDTH, SEG_W);

  if (SEG_W < 1) begin : g_bad_seg
    $error("adder_pipe: SEG_W must be at least 1");
  end else if (WIDTH % SEG_W != 0) begin : g_bad_div
    $error("adder_pipe: WIDTH must be a multiple of SEG_W");
  end

  // acc holds finished sum segments below the current stage and the still
  // pending A segments above it, so one vector carries both forward.
  // opb carries the B operand; its lower segments are simply dead weight.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opb;
    add_flags_t       flg;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t           stg_p  [STAGES];
  stage_t           src    [STAGES];
  stage_t           nxt    [STAGES];
  logic [SEG_W-1:0] seg_a  [STAGES];
  logic [SEG_W-1:0] seg_b  [STAGES];
  logic [SEG_W-1:0] seg_s  [STAGES];
  logic             seg_ci [STAGES];
  logic             seg_co [STAGES];
  logic             seg_mc [STAGES];
  logic             stall;

  assign stall    = stg_p[STAGES-1].vld & ~out_ready;
  assign in_ready = ~stall;

  // Stage k works on what stage k-1 registered; stage 0 on the ports.
  always_comb begin : src_sel
    src[0].vld      = in_valid;
    src[0].acc      = in_a;
    src[0].opb      = in_b;
    src[0].flg.cout = in_cin;
    src[0].flg.ovf  = 1'b0;
    src[0].tag      = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      src[k] = stg_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_a[k]  = src[k].acc[k*SEG_W +: SEG_W];
      seg_b[k]  = src[k].opb[k*SEG_W +: SEG_W];
      seg_ci[k] = src[k].flg.cout;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a       (seg_a[k]),
      .b       (seg_b[k]),
      .cin     (seg_ci[k]),
      .s       (seg_s[k]),
      .cout    (seg_co[k]),
      .msb_cin (seg_mc[k])
    );
  end

  always_comb begin : stage_next
    for (int k = 0; k < STAGES; k++) begin
      nxt[k]                        = src[k];
      nxt[k].acc[k*SEG_W +: SEG_W]  = seg_s[k];
      nxt[k].flg.cout               = seg_co[k];
      nxt[k].flg.ovf                = (k == STAGES-1) ? (seg_mc[k] ^ seg_co[k]) : 1'b0;
    end
  end

  // Whole pipeline moves together; a stall freezes every stage, and
  // bubbles travel like transactions (nothing is collapsed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_p[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        stg_p[k] <= nxt[k];
      end
    end
  end

  assign out_valid = stg_p[STAGES-1].vld;
  assign out_sum   = stg_p[STAGES-1].acc;
  assign out_cout  = stg_p[STAGES-1].flg.cout;
  assign out_ovf   = stg_p[STAGES-1].flg.ovf;
  assign out_tag   = stg_p[STAGES-1].tag;

endmodule
